divider_core: RTL and testbench
===============================

// Module: divider_core
// PURPOSE
//  Sequential unsigned integer divider (restoring, one quotient bit per clock).
//  Takes a start request with dividend/divisor, returns quotient and remainder with a done pulse.
//  Used as a shared arithmetic unit behind a simple start/done handshake driven by a control FSM.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; also the iteration count
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  start_sig  in   1      level request; sampled only in IDLE
//  dividend   in   WIDTH  unsigned dividend, captured on accepting edge
//  divisor    in   WIDTH  unsigned divisor, captured on accepting edge
//  done_sig   out  1      one-cycle completion pulse
//  quotient   out  WIDTH  registered quotient, valid from done_sig onward
//  remainder  out  WIDTH  registered remainder, valid from done_sig onward
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, done_sig=0, quotient=0, remainder=0, internal regs 0.
//    Reset mid-operation aborts the divide; no done_sig is produced for it.
//  - States: IDLE -> CALC -> DONE -> WAIT -> IDLE.
//  - IDLE: on edge with start_sig=1, capture dividend/divisor into internal regs,
//    clear partial remainder (WIDTH+1 bits), step count=0, go CALC. Else stay.
//  - CALC: per edge, shift {partial_rem, dividend_reg} left 1; if partial_rem >= divisor,
//    subtract divisor and shift in quotient bit 1, else 0. After WIDTH steps go DONE.
//  - Latency: accepting edge E0; iterations on E1..E(WIDTH); at E(WIDTH) the results are
//    written to quotient/remainder and done_sig goes 1. WIDTH=8: done visible 8 cycles after accept.
//  - DONE: done_sig=1 for exactly one cycle; next edge clears done_sig, go WAIT.
//  - WAIT: stay until start_sig=0 sampled, then IDLE. Prevents retrigger from a held start level;
//    a new request must deassert start_sig for >=1 edge. Requester drops start on seeing done.
//  - Inputs are ignored outside IDLE; operand changes during CALC do not affect the result.
//  - quotient/remainder hold last result until the next completion (not cleared on new start).
//  - Divide by zero: same latency; quotient = all ones (8'hFF), remainder = dividend.
//  - Unsigned only; dividend < divisor gives quotient 0, remainder = dividend.
//  - done_sig is registered.
// TESTING
//  - 9/3 -> quotient 3, remainder 0; done_sig high one cycle, 8 cycles after accept.
//  - Back-to-back sequence 3/9, 8/2, 8/4, 8/3 with start dropped on done
//    -> (0,3), (4,0), (2,0), (2,2) in order, one done pulse each.
//  - 255/1 -> (255,0); 255/255 -> (1,0); 0/7 -> (0,0).
//  - 17/0 -> quotient 8'hFF, remainder 17, normal latency.
//  - start_sig held high through done -> exactly one done pulse, no restart until start low.
//  - rst asserted during CALC -> outputs 0, done_sig never pulses; next 8/3 request -> (2,2).

Source files
------------

// File: rtl/divider_core.sv
// rtl/divider_core.sv - sequential restoring unsigned divider, one quotient bit per clock
//
// Purpose:
//   Accepts a start request in IDLE, captures dividend/divisor and runs WIDTH
//   restoring-division steps. Then it publishes quotient/remainder with a
//   one-cycle done pulse. It waits for start to drop before it re-arms.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   start_sig  in   1      level request, sampled only in IDLE
//   dividend   in   WIDTH  unsigned dividend, captured on the accepting edge
//   divisor    in   WIDTH  unsigned divisor, captured on the accepting edge
//   done_sig   out  1      registered one-cycle completion pulse
//   quotient   out  WIDTH  last completed quotient (all ones on divide by zero)
//   remainder  out  WIDTH  last completed remainder (dividend on divide by zero)

module divider_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_sig,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done_sig,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE,
    S_WAIT
  } state_t;

  state_t state, state_next;

  // The settled partial remainder is always below 2^WIDTH. A divide by zero
  // also stays within it, because the remainder never exceeds the dividend.
  // The extra (WIDTH+1)th bit is therefore needed only in the shifted trial value.
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvd_reg;   // dividend shifts out the top, quotient bits shift in
  logic [WIDTH-1:0] dvs_reg;
  logic [CW-1:0]    step_cnt;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   trial_diff;
  logic             trial_ge;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic             last_step;

  always_comb begin
    trial      = {rem_reg, dvd_reg[WIDTH-1]};
    trial_ge   = (trial >= {1'b0, dvs_reg});
    trial_diff = trial - {1'b0, dvs_reg};
    rem_next   = trial_ge ? trial_diff : trial;
    dvd_next   = {dvd_reg[WIDTH-2:0], trial_ge};
    last_step  = (step_cnt == LAST_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start_sig)  state_next = S_CALC;
      S_CALC: if (last_step)  state_next = S_DONE;
      S_DONE:                 state_next = S_WAIT;
      S_WAIT: if (!start_sig) state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg   <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      step_cnt  <= '0;
      done_sig  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done_sig <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_sig) begin
            rem_reg  <= '0;
            dvd_reg  <= dividend;
            dvs_reg  <= divisor;
            step_cnt <= '0;
          end
        end
        S_CALC: begin
          rem_reg  <= rem_next[WIDTH-1:0];
          dvd_reg  <= dvd_next;
          step_cnt <= step_cnt + 1'b1;
          // Results are published on the same edge as the final step,
          // so done appears WIDTH cycles after the accepting edge.
          if (last_step) begin
            quotient  <= dvd_next;
            remainder <= rem_next[WIDTH-1:0];
            done_sig  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_core.sv
// tb/tb_divider_core.sv - self-checking bench for divider_core

module tb_divider_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_sig;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         done_sig;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int errors = 0;

  divider_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_sig (start_sig),
    .dividend  (dividend),
    .divisor   (divisor),
    .done_sig  (done_sig),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int q, r;
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q[W-1:0], r[W-1:0]};
  endfunction

  // Issue one request at a negedge, optionally scramble the operands after
  // acceptance, wait for done with a bound, check results and pulse width.
  // With hold=1, start stays high long enough that a retrigger would show.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input string tag);
    logic [2*W-1:0] exp;
    int edges;
    bit seen;
    exp       = ref_div(a, b);
    start_sig = 1'b1;
    dividend  = a;
    divisor   = b;
    edges     = 0;
    seen      = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      if (done_sig) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, " timeout"}, 0, 1);
    end else begin
      check({tag, " latency"}, edges - 1, 8);
      check({tag, " quotient"}, quotient, exp[2*W-1:W]);
      check({tag, " remainder"}, remainder, exp[W-1:0]);
    end
    if (hold) begin
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        check({tag, " held no done"}, done_sig, 0);
      end
      check({tag, " held result"}, {quotient, remainder}, exp);
    end
    start_sig = 1'b0;
    @(negedge clk);
    check({tag, " done one cycle"}, done_sig, 0);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ta [9];
    logic [W-1:0] tb [9];
    logic [W-1:0] ra, rb;
    ta = '{9, 3, 8, 8, 8, 255, 255, 0, 17};
    tb = '{3, 9, 2, 4, 3, 1, 255, 7, 0};

    rst = 1'b1;
    start_sig = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    check("reset done", done_sig, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_div(ta[i], tb[i], 1'b0, $sformatf("dir%0d_%0d/%0d", i, ta[i], tb[i]));
    end

    do_div(8'd200, 8'd7, 1'b1, "hold");

    // Reset in the middle of a divide aborts it without a done pulse.
    start_sig = 1'b1;
    dividend  = 8'd100;
    divisor   = 8'd9;
    repeat (3) @(negedge clk);
    start_sig = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst done", done_sig, 0);
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (done_sig) pulses++;
      end
      check("midrst no pulse", pulses, 0);
    end
    do_div(8'd8, 8'd3, 1'b0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_div(ra, rb, 1'b0, $sformatf("rnd%0d_%0d/%0d", i, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
